// File: rtl/dmem_burst_master.sv
// dmem_burst_master: sequences one load/store burst onto a single-port
// data memory, one word per cycle, and gathers read words into lanes.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store burst, 0 = load burst
//   req_addr            base word address
//   req_len             word count (0 -> 1, clamped to MAX_BURST)
//   req_wdata           store lanes, lane i at [i*DATA_W +: DATA_W]
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           gathered load lanes, same packing
//   mem_addr/wdata/we   memory port, registered
//   mem_rdata           memory read data, RD_LAT cycles after mem_addr
module dmem_burst_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [$clog2(MAX_BURST):0]  req_len,
  input  logic [MAX_BURST*DATA_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [MAX_BURST*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LEN_W   = $clog2(MAX_BURST) + 1;
  localparam int LANES_W = MAX_BURST * DATA_W;
  localparam int DRN_W   = $clog2(RD_LAT + 1) + 1;

  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_beat_nx;
  logic [LANES_W-1:0] r_wdata;
  logic [LANES_W-1:0] r_rdata;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_we;
  logic [DRN_W-1:0]   r_drain;

  logic               w_accept;
  logic               w_issue;
  logic               w_last;
  logic               w_rsp;
  logic               w_cap_v;
  logic [LEN_W-1:0]   w_cap_idx;

  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;
  assign w_issue   = (r_state == S_READ);
  assign w_last    = (r_beat == r_len - LEN_W'(1));
  assign w_beat_nx = r_beat + LEN_W'(1);

  assign rsp_valid = w_rsp;
  assign rsp_rdata = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

  always_comb begin
    w_len_eff = req_len;
    if (req_len == '0) begin
      w_len_eff = LEN_W'(1);
    end else if (req_len > MAX_LEN) begin
      w_len_eff = MAX_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_rsp  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = req_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_READ: begin
        if (w_last) begin
          w_next = (RD_LAT == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == DRN_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_rsp  = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Read beat tags travel alongside the memory latency so each
  // returning word lands in the lane of the address that asked for it.
  if (RD_LAT == 0) begin : g_lat0
    assign w_cap_v   = w_issue;
    assign w_cap_idx = r_beat;
  end else begin : g_latn
    logic [RD_LAT-1:0] r_cap_v;
    logic [LEN_W-1:0]  r_cap_idx [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cap_v <= '0;
        for (int i = 0; i < RD_LAT; i++) begin
          r_cap_idx[i] <= '0;
        end
      end else begin
        r_cap_v[0]   <= w_issue;
        r_cap_idx[0] <= r_beat;
        for (int i = 1; i < RD_LAT; i++) begin
          r_cap_v[i]   <= r_cap_v[i-1];
          r_cap_idx[i] <= r_cap_idx[i-1];
        end
      end
    end

    assign w_cap_v   = r_cap_v[RD_LAT-1];
    assign w_cap_idx = r_cap_idx[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_beat      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_drain     <= '0;
    end else begin
      if (w_cap_v) begin
        r_rdata[w_cap_idx*DATA_W +: DATA_W] <= mem_rdata;
      end

      if (r_state == S_DRAIN) begin
        r_drain <= r_drain + DRN_W'(1);
      end else begin
        r_drain <= '0;
      end

      if (w_accept) begin
        // First beat is presented straight from the request so the
        // memory sees it in the cycle right after the accept.
        r_len       <= w_len_eff;
        r_beat      <= '0;
        r_wdata     <= req_wdata;
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_wdata[DATA_W-1:0];
        r_mem_we    <= req_we;
        if (!req_we) begin
          for (int i = 0; i < MAX_BURST; i++) begin
            if (LEN_W'(i) >= w_len_eff) begin
              r_rdata[i*DATA_W +: DATA_W] <= '0;
            end
          end
        end
      end else if (r_state == S_WRITE ||
                   r_state == S_READ) begin
        if (w_last) begin
          r_mem_we <= 1'b0;
        end else begin
          r_beat      <= w_beat_nx;
          r_mem_addr  <= r_mem_addr + ADDR_W'(1);
          r_mem_wdata <= r_wdata[w_beat_nx*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_burst_master.sv
// tb_dmem_burst_master: three instances (RD_LAT 0/1/2) share stimulus;
// a word-addressed memory model and a reference store give expectations.
module tb_dmem_burst_master;

  localparam int WIN = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rv;
  logic         t_we;
  logic [31:0]  t_addr;
  logic [2:0]   t_len;
  logic [127:0] t_wd;

  logic [2:0]   rdy;
  logic [2:0]   rsv;
  logic [2:0]   mwe;
  logic [31:0]  ma   [3];
  logic [31:0]  mwd  [3];
  logic [127:0] rdat [3];
  logic [31:0]  md0, md1, md2, rp2a;

  dmem_burst_master #(.RD_LAT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(t_we), .req_addr(t_addr),
    .req_len(t_len), .req_wdata(t_wd),
    .rsp_valid(rsv[0]), .rsp_rdata(rdat[0]),
    .mem_addr(ma[0]), .mem_wdata(mwd[0]),
    .mem_we(mwe[0]), .mem_rdata(md0)
  );

  dmem_burst_master #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(t_we), .req_addr(t_addr),
    .req_len(t_len), .req_wdata(t_wd),
    .rsp_valid(rsv[1]), .rsp_rdata(rdat[1]),
    .mem_addr(ma[1]), .mem_wdata(mwd[1]),
    .mem_we(mwe[1]), .mem_rdata(md1)
  );

  dmem_burst_master #(.RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(t_we), .req_addr(t_addr),
    .req_len(t_len), .req_wdata(t_wd),
    .rsp_valid(rsv[2]), .rsp_rdata(rdat[2]),
    .mem_addr(ma[2]), .mem_wdata(mwd[2]),
    .mem_we(mwe[2]), .mem_rdata(md2)
  );

  // Physical memory (written by instance 1) and reference store
  // (written by the bench model from the requests themselves).
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  int mem_gen = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  always @(ma[0] or mem_gen) md0 = rd(ma[0]);

  always @(posedge clk) begin
    md1  <= rd(ma[1]);
    rp2a <= rd(ma[2]);
    md2  <= rp2a;
    if (mwe[1]) begin
      mem[ma[1]] = mwd[1];
      mem_gen = mem_gen + 1;
    end
  end

  function automatic int leff(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (l > 3'd4) return 4;
    return int'(l);
  endfunction

  function automatic int rsp_at(input logic we, input int n, input int lat);
    return 1 + n + (we ? 0 : lat);
  endfunction

  function automatic logic [127:0] load_exp(input logic [31:0] a, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*32 +: 32] = ref_rd(a + 32'(i));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [127:0] wd);
    for (int i = 0; i < n; i++) refm[a + 32'(i)] = wd[i*32 +: 32];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    refm[a] = v;
    mem_gen = mem_gen + 1;
  endtask

  int n_chk = 0;
  int n_pass = 0;
  logic [127:0] exp_rdata = '0;

  logic         o_we [3][WIN+1];
  logic [31:0]  o_a  [3][WIN+1];
  logic [31:0]  o_wd [3][WIN+1];
  logic         o_rv [3][WIN+1];
  int           o_rsp[3];
  int           acc2 [3];
  logic [127:0] o_rd [3];
  logic [2:0]   pre_rdy;

  // Drive one request to all instances and record WIN cycles of outputs.
  // With hold set, req_valid stays high until each instance re-accepts.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [2:0] len, input logic [127:0] wd,
                       input bit hold);
    @(negedge clk);
    t_we = we; t_addr = addr; t_len = len; t_wd = wd;
    rv = 3'b111;
    pre_rdy = rdy;
    for (int k = 0; k < 3; k++) begin
      o_rsp[k] = -1; acc2[k] = -1; o_rd[k] = 'x;
    end
    @(posedge clk); #1;
    if (!hold) rv = 3'b000;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        o_we[k][c] = mwe[k];
        o_a[k][c]  = ma[k];
        o_wd[k][c] = mwd[k];
        o_rv[k][c] = rsv[k];
        if (rsv[k] && o_rsp[k] < 0) begin
          o_rsp[k] = c; o_rd[k] = rdat[k];
        end
        if (hold && rv[k] && rdy[k] && acc2[k] < 0) acc2[k] = c;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (acc2[k] == c) rv[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [127:0] wd;
    wd = 128'h44444444_33333333_22222222_11111111;
    rst_n = 1'b0; rv = '0;
    t_we = 0; t_addr = '0; t_len = '0; t_wd = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (rdy[k] !== 1'b0) $display("FAIL rst_ready dut%0d got %b want 0", k, rdy[k]); else n_pass++;
      n_chk++; if (mwe[k] !== 1'b0) $display("FAIL rst_we dut%0d got %b want 0", k, mwe[k]); else n_pass++;
      n_chk++; if (ma[k] !== 32'h0) $display("FAIL rst_addr dut%0d got %h want 0", k, ma[k]); else n_pass++;
      n_chk++; if (mwd[k] !== 32'h0) $display("FAIL rst_wdata dut%0d got %h want 0", k, mwd[k]); else n_pass++;
      n_chk++; if (rsv[k] !== 1'b0) $display("FAIL rst_rspv dut%0d got %b want 0", k, rsv[k]); else n_pass++;
      n_chk++; if (rdat[k] !== 128'h0) $display("FAIL rst_rdata dut%0d got %h want 0", k, rdat[k]); else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy !== 3'b111) $display("FAIL rel_ready got %b want 111", rdy); else n_pass++;
    t_we = 1; t_addr = 32'h100; t_len = 3'd4; t_wd = wd; rv = 3'b111;
    @(posedge clk); #1;
    rv = 3'b000;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (mwe !== 3'b111) $display("FAIL beat1_we got %b want 111", mwe); else n_pass++;
    n_chk++; if (ma[1] !== 32'h101) $display("FAIL beat1_addr got %h want 101", ma[1]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (mwe !== 3'b000) $display("FAIL abort_we got %b want 000", mwe); else n_pass++;
    n_chk++; if (rdy !== 3'b000) $display("FAIL abort_ready got %b want 000", rdy); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (rsv !== 3'b000) $display("FAIL abort_rspv got %b want 000", rsv); else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy !== 3'b111) $display("FAIL post_rel_ready got %b want 111", rdy); else n_pass++;
    repeat (6) begin
      @(negedge clk);
      n_chk++; if (rsv !== 3'b000) $display("FAIL post_rel_rspv got %b want 000", rsv); else n_pass++;
    end
    model_store(32'h100, 1, wd);
    exp_rdata = '0;
  endtask

  task automatic test_store_single;
    issue(1'b1, 32'h4, 3'd1, 128'hDEADBEEF_CAFEF00D_12345678_00000007, 0);
    model_store(32'h4, 1, 128'h7);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_we[k][1] !== 1'b1) $display("FAIL st1_we dut%0d got %b want 1", k, o_we[k][1]); else n_pass++;
      n_chk++; if (o_a[k][1] !== 32'h4) $display("FAIL st1_addr dut%0d got %h want 4", k, o_a[k][1]); else n_pass++;
      n_chk++; if (o_wd[k][1] !== 32'h7) $display("FAIL st1_wdata dut%0d got %h want 7", k, o_wd[k][1]); else n_pass++;
      n_chk++; if (o_we[k][2] !== 1'b0) $display("FAIL st1_we_off dut%0d got %b want 0", k, o_we[k][2]); else n_pass++;
      n_chk++; if (o_rsp[k] !== 2) $display("FAIL st1_rsp_cyc dut%0d got %0d want 2", k, o_rsp[k]); else n_pass++;
      n_chk++; if (o_rv[k][3] !== 1'b0) $display("FAIL st1_rsp_pulse dut%0d got %b want 0", k, o_rv[k][3]); else n_pass++;
      n_chk++; if (o_rd[k] !== exp_rdata) $display("FAIL st1_rdata dut%0d got %h want %h", k, o_rd[k], exp_rdata); else n_pass++;
    end
    n_chk++; if (rd(32'h4) !== 32'h7) $display("FAIL st1_mem got %h want 7", rd(32'h4)); else n_pass++;
  endtask

  task automatic test_load_burst;
    logic [127:0] want;
    want = 128'h000000A3_000000A2_000000A1_000000A0;
    for (int i = 0; i < 4; i++) preload(32'(i), 32'hA0 + 32'(i));
    issue(1'b0, 32'h0, 3'd4, '0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 4; c++) begin
        n_chk++; if (o_a[k][c] !== 32'(c-1) || o_we[k][c] !== 1'b0)
          $display("FAIL ld4_beat dut%0d c%0d got %h/%b want %h/0", k, c, o_a[k][c], o_we[k][c], c-1);
        else n_pass++;
      end
      n_chk++; if (o_rsp[k] !== 5 + k) $display("FAIL ld4_rsp_cyc dut%0d got %0d want %0d", k, o_rsp[k], 5+k); else n_pass++;
      n_chk++; if (o_rv[k][6+k] !== 1'b0) $display("FAIL ld4_rsp_pulse dut%0d got %b want 0", k, o_rv[k][6+k]); else n_pass++;
      n_chk++; if (o_rd[k] !== want) $display("FAIL ld4_rdata dut%0d got %h want %h", k, o_rd[k], want); else n_pass++;
    end
    exp_rdata = want;
  endtask

  task automatic test_roundtrip;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 32'h10, 3'd4, d, 0);
    model_store(32'h10, 4, d);
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 4; c++) begin
        n_chk++; if (o_we[k][c] !== 1'b1 || o_a[k][c] !== 32'h10 + 32'(c-1) || o_wd[k][c] !== d[(c-1)*32 +: 32])
          $display("FAIL st4_beat dut%0d c%0d got %b/%h/%h want 1/%h/%h", k, c, o_we[k][c], o_a[k][c], o_wd[k][c], 32'h10 + 32'(c-1), d[(c-1)*32 +: 32]);
        else n_pass++;
      end
      n_chk++; if (o_rsp[k] !== 5) $display("FAIL st4_rsp_cyc dut%0d got %0d want 5", k, o_rsp[k]); else n_pass++;
    end
    issue(1'b0, 32'h10, 3'd4, '0, 0);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_rd[k] !== d) $display("FAIL rt4_rdata dut%0d got %h want %h", k, o_rd[k], d); else n_pass++;
    end
    issue(1'b0, 32'h10, 3'd2, '0, 0);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_rd[k] !== {64'h0, d[63:0]}) $display("FAIL rt2_rdata dut%0d got %h want %h", k, o_rd[k], {64'h0, d[63:0]}); else n_pass++;
      n_chk++; if (o_rsp[k] !== 3 + k) $display("FAIL rt2_rsp_cyc dut%0d got %0d want %0d", k, o_rsp[k], 3+k); else n_pass++;
    end
    exp_rdata = {64'h0, d[63:0]};
  endtask

  task automatic test_wrap;
    logic [31:0] wa [4];
    logic [127:0] want;
    wa = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    want = load_exp(32'hFFFFFFFE, 4);
    issue(1'b0, 32'hFFFFFFFE, 3'd4, '0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 4; c++) begin
        n_chk++; if (o_a[k][c] !== wa[c-1]) $display("FAIL wrap_addr dut%0d c%0d got %h want %h", k, c, o_a[k][c], wa[c-1]); else n_pass++;
      end
      n_chk++; if (o_rsp[k] !== 5 + k) $display("FAIL wrap_rsp_cyc dut%0d got %0d want %0d", k, o_rsp[k], 5+k); else n_pass++;
      n_chk++; if (o_rd[k] !== want) $display("FAIL wrap_rdata dut%0d got %h want %h", k, o_rd[k], want); else n_pass++;
    end
    exp_rdata = want;
  endtask

  task automatic test_corner_len;
    logic [127:0] d;
    logic [127:0] want;
    d = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 32'h40, 3'd0, d, 0);
    model_store(32'h40, 1, d);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_we[k][1] !== 1'b1 || o_a[k][1] !== 32'h40 || o_wd[k][1] !== d[31:0])
        $display("FAIL len0_beat dut%0d got %b/%h/%h want 1/40/%h", k, o_we[k][1], o_a[k][1], o_wd[k][1], d[31:0]);
      else n_pass++;
      n_chk++; if (o_we[k][2] !== 1'b0) $display("FAIL len0_we_off dut%0d got %b want 0", k, o_we[k][2]); else n_pass++;
      n_chk++; if (o_rsp[k] !== 2) $display("FAIL len0_rsp_cyc dut%0d got %0d want 2", k, o_rsp[k]); else n_pass++;
    end
    want = load_exp(32'h40, 4);
    issue(1'b0, 32'h40, 3'd7, '0, 0);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_a[k][4] !== 32'h43 || o_a[k][5] !== 32'h43)
        $display("FAIL len7_addr dut%0d got %h,%h want 43,43", k, o_a[k][4], o_a[k][5]);
      else n_pass++;
      n_chk++; if (o_rsp[k] !== 5 + k) $display("FAIL len7_rsp_cyc dut%0d got %0d want %0d", k, o_rsp[k], 5+k); else n_pass++;
      n_chk++; if (o_rd[k] !== want) $display("FAIL len7_rdata dut%0d got %h want %h", k, o_rd[k], want); else n_pass++;
    end
    exp_rdata = want;
  endtask

  task automatic test_hold_off;
    logic [127:0] want;
    int np;
    want = load_exp(32'h20, 4);
    issue(1'b0, 32'h20, 3'd4, '0, 1);
    for (int k = 0; k < 3; k++) begin
      np = 0;
      for (int c = 1; c <= WIN; c++) if (o_rv[k][c] === 1'b1) np++;
      n_chk++; if (o_rsp[k] !== rsp_at(1'b0, 4, k)) $display("FAIL hold_rsp_cyc dut%0d got %0d want %0d", k, o_rsp[k], rsp_at(1'b0, 4, k)); else n_pass++;
      n_chk++; if (acc2[k] !== rsp_at(1'b0, 4, k) + 1) $display("FAIL hold_accept dut%0d got %0d want %0d", k, acc2[k], rsp_at(1'b0, 4, k) + 1); else n_pass++;
      n_chk++; if (np !== 2) $display("FAIL hold_rsp_count dut%0d got %0d want 2", k, np); else n_pass++;
      n_chk++; if (o_rd[k] !== want) $display("FAIL hold_rdata dut%0d got %h want %h", k, o_rd[k], want); else n_pass++;
    end
    exp_rdata = want;
  endtask

  task automatic test_random;
    logic we;
    logic [31:0] a;
    logic [2:0] len;
    logic [127:0] wd;
    logic [127:0] want;
    int n, ra;
    for (int it = 0; it < 30; it++) begin
      we  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'h200 + 32'($urandom_range(0, 15));
      len = 3'($urandom_range(0, 7));
      wd  = {$urandom, $urandom, $urandom, $urandom};
      n   = leff(len);
      want = we ? exp_rdata : load_exp(a, n);
      issue(we, a, len, wd, 0);
      n_chk++; if (pre_rdy !== 3'b111) $display("FAIL rnd_ready it%0d got %b want 111", it, pre_rdy); else n_pass++;
      for (int k = 0; k < 3; k++) begin
        ra = rsp_at(we, n, k);
        for (int c = 1; c <= WIN; c++) begin
          n_chk++; if (o_we[k][c] !== (we && c <= n)) $display("FAIL rnd_we it%0d dut%0d c%0d got %b want %b", it, k, c, o_we[k][c], we && c <= n); else n_pass++;
          n_chk++; if (o_a[k][c] !== a + 32'((c <= n ? c : n) - 1)) $display("FAIL rnd_addr it%0d dut%0d c%0d got %h want %h", it, k, c, o_a[k][c], a + 32'((c <= n ? c : n) - 1)); else n_pass++;
          if (we && c <= n) begin
            n_chk++; if (o_wd[k][c] !== wd[(c-1)*32 +: 32]) $display("FAIL rnd_wdata it%0d dut%0d c%0d got %h want %h", it, k, c, o_wd[k][c], wd[(c-1)*32 +: 32]); else n_pass++;
          end
          n_chk++; if (o_rv[k][c] !== (c == ra)) $display("FAIL rnd_rspv it%0d dut%0d c%0d got %b want %b", it, k, c, o_rv[k][c], c == ra); else n_pass++;
        end
        n_chk++; if (o_rd[k] !== want) $display("FAIL rnd_rdata it%0d dut%0d got %h want %h", it, k, o_rd[k], want); else n_pass++;
      end
      if (we) model_store(a, n, wd);
      exp_rdata = want;
    end
  endtask

  initial begin
    test_reset();
    test_store_single();
    test_load_burst();
    test_roundtrip();
    test_wrap();
    test_corner_len();
    test_hold_off();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
